// File: rtl/qu_common_pkg.sv
// Shared reservation-station types: entry index, cell layout and the CDB operand snoop.
package qu_common;

  localparam int RES_ST_DEPTH_DFLT  = 8;
  localparam int RES_ST_ADDR_WIDTH  = $clog2(RES_ST_DEPTH_DFLT);
  localparam int PHY_RF_ADDR_WIDTH  = 6;
  localparam int RES_ST_OP_WIDTH    = 4;

  typedef logic [RES_ST_ADDR_WIDTH-1:0] res_st_addr_t;
  typedef logic [PHY_RF_ADDR_WIDTH-1:0] phy_tag_t;

  typedef struct packed {
    phy_tag_t                   qj;
    logic [31:0]                vj;
    phy_tag_t                   qk;
    logic [31:0]                vk;
    logic [31:0]                a;
    logic [RES_ST_OP_WIDTH-1:0] op;
    logic                       busy;
  } res_st_cell_t;

  // Capture a broadcast value into any operand still waiting on that tag; tag 0 is never a producer.
  function automatic res_st_cell_t snoop(input res_st_cell_t c, input logic valid,
                                         input phy_tag_t tag, input logic [31:0] data);
    res_st_cell_t r;
    r = c;
    if (valid && tag != '0) begin
      if (c.qj == tag) begin
        r.qj = '0;
        r.vj = data;
      end
      if (c.qk == tag) begin
        r.qk = '0;
        r.vk = data;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/res_st_buffer_select.sv
// Fixed-priority picker: reports whether any entry is ready and the lowest ready index.
module res_st_select
  import qu_common::*;
#(
  parameter int DEPTH = RES_ST_DEPTH_DFLT
) (
  input  logic [DEPTH-1:0] ready,
  output logic             found,
  output res_st_addr_t     idx
);

  // NOTE: always_comb uses blocking assignments and defaults every output first, so no latch is inferred.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Scan downward so the lowest ready index is the last one written.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        found = 1'b1;
        idx   = res_st_addr_t'(i);
      end
    end
  end

endmodule

// File: rtl/res_st_buffer.sv
// Reservation-station storage: accepts renamed ops, wakes operands from the CDB and issues
// the lowest ready entry through a registered valid/ready output stage.
module res_st_buffer
  import qu_common::*;
#(
  parameter int RES_ST_DEPTH = RES_ST_DEPTH_DFLT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_in,
  input  logic                         wr_en_in,
  input  res_st_addr_t                 wr_addr_in,
  input  res_st_cell_t                 wr_data_in,
  input  logic                         cdb_valid_in,
  input  logic [PHY_RF_ADDR_WIDTH-1:0] cdb_tag_in,
  input  logic [31:0]                  cdb_data_in,
  output logic                         issue_valid_out,
  input  logic                         issue_ready_in,
  output res_st_addr_t                 issue_idx_out,
  output res_st_cell_t                 issue_data_out,
  output logic [RES_ST_DEPTH-1:0]      busy_vec_out,
  output logic                         full_out,
  output logic                         overflow_out
);

  res_st_cell_t              payload [RES_ST_DEPTH];
  logic [RES_ST_DEPTH-1:0]   busy_q;
  logic [RES_ST_DEPTH-1:0]   busy_d;
  logic [RES_ST_DEPTH-1:0]   ready;
  logic                      sel_found;
  res_st_addr_t              sel_idx;
  logic                      load;
  logic                      wr_accept;
  logic                      full_q;
  res_st_cell_t              wr_cell;

  always_comb begin
    ready = '0;
    for (int i = 0; i < RES_ST_DEPTH; i++) begin
      ready[i] = busy_q[i] && payload[i].qj == '0 && payload[i].qk == '0;
    end
  end

  res_st_select #(.DEPTH(RES_ST_DEPTH)) u_select (
    .ready (ready),
    .found (sel_found),
    .idx   (sel_idx)
  );

  assign load      = sel_found && (!issue_valid_out || issue_ready_in);
  // An entry leaving through the issue port this cycle may be overwritten at the same edge.
  assign wr_accept = wr_en_in && (!busy_q[wr_addr_in] || (load && sel_idx == wr_addr_in));

  always_comb begin
    wr_cell      = snoop(wr_data_in, cdb_valid_in, cdb_tag_in, cdb_data_in);
    wr_cell.busy = 1'b1;
  end

  always_comb begin
    busy_d = busy_q;
    if (load)      busy_d[sel_idx]    = 1'b0;
    if (wr_accept) busy_d[wr_addr_in] = 1'b1;
  end

  // NOTE: payload storage has no reset; the busy bits alone decide whether an entry holds anything.
  always_ff @(posedge clk) begin
    if (!flush_in) begin
      for (int i = 0; i < RES_ST_DEPTH; i++) begin
        if (busy_q[i]) payload[i] <= snoop(payload[i], cdb_valid_in, cdb_tag_in, cdb_data_in);
      end
      if (wr_accept) payload[wr_addr_in] <= wr_cell;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q          <= '0;
      full_q          <= 1'b0;
      overflow_out    <= 1'b0;
      issue_valid_out <= 1'b0;
      issue_idx_out   <= '0;
      issue_data_out  <= '0;
    end else if (flush_in) begin
      busy_q          <= '0;
      full_q          <= 1'b0;
      overflow_out    <= 1'b0;
      issue_valid_out <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      full_q       <= &busy_d;
      overflow_out <= wr_en_in && !wr_accept;
      if (load) begin
        issue_valid_out <= 1'b1;
        issue_idx_out   <= sel_idx;
        issue_data_out  <= payload[sel_idx];
      end else if (issue_ready_in) begin
        issue_valid_out <= 1'b0;
      end
    end
  end

  assign busy_vec_out = busy_q;
  assign full_out     = full_q;

endmodule

// File: tb/tb_res_st_buffer.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level behavioural model.
module tb_res_st_buffer;
  import qu_common::*;

  localparam int DEPTH = RES_ST_DEPTH_DFLT;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         flush_in = 1'b0;
  logic                         wr_en_in = 1'b0;
  res_st_addr_t                 wr_addr_in = '0;
  res_st_cell_t                 wr_data_in = '0;
  logic                         cdb_valid_in = 1'b0;
  logic [PHY_RF_ADDR_WIDTH-1:0] cdb_tag_in = '0;
  logic [31:0]                  cdb_data_in = '0;
  logic                         issue_valid_out;
  logic                         issue_ready_in = 1'b1;
  res_st_addr_t                 issue_idx_out;
  res_st_cell_t                 issue_data_out;
  logic [DEPTH-1:0]             busy_vec_out;
  logic                         full_out;
  logic                         overflow_out;

  res_st_buffer #(.RES_ST_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush_in        (flush_in),
    .wr_en_in        (wr_en_in),
    .wr_addr_in      (wr_addr_in),
    .wr_data_in      (wr_data_in),
    .cdb_valid_in    (cdb_valid_in),
    .cdb_tag_in      (cdb_tag_in),
    .cdb_data_in     (cdb_data_in),
    .issue_valid_out (issue_valid_out),
    .issue_ready_in  (issue_ready_in),
    .issue_idx_out   (issue_idx_out),
    .issue_data_out  (issue_data_out),
    .busy_vec_out    (busy_vec_out),
    .full_out        (full_out),
    .overflow_out    (overflow_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: entries as an array of cells, output stage as plain variables.
  res_st_cell_t m_cell [DEPTH];
  bit           m_valid;
  int           m_idx;
  res_st_cell_t m_data;
  bit           m_ov;

  function automatic res_st_cell_t wake(input res_st_cell_t c);
    res_st_cell_t r = c;
    if (cdb_valid_in && cdb_tag_in != 0) begin
      if (r.qj == cdb_tag_in) begin r.qj = 0; r.vj = cdb_data_in; end
      if (r.qk == cdb_tag_in) begin r.qk = 0; r.vk = cdb_data_in; end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_cell[i].busy = 1'b0;
    m_valid = 0;
    m_idx   = 0;
    m_data  = '0;
    m_ov    = 0;
  endtask

  task automatic model_step();
    res_st_cell_t nxt [DEPTH];
    int sel;
    bit take;
    if (flush_in) begin
      for (int i = 0; i < DEPTH; i++) m_cell[i].busy = 1'b0;
      m_valid = 0;
      m_ov    = 0;
      return;
    end
    sel = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel < 0 && m_cell[i].busy && m_cell[i].qj == 0 && m_cell[i].qk == 0) sel = i;
    end
    take = (sel >= 0) && (!m_valid || issue_ready_in);
    nxt = m_cell;
    if (take) begin
      m_data = m_cell[sel];
      m_idx  = sel;
      m_valid = 1;
      nxt[sel].busy = 1'b0;
    end else if (issue_ready_in) begin
      m_valid = 0;
    end
    for (int i = 0; i < DEPTH; i++) if (nxt[i].busy) nxt[i] = wake(nxt[i]);
    m_ov = 0;
    if (wr_en_in) begin
      if (!m_cell[int'(wr_addr_in)].busy || (take && sel == int'(wr_addr_in))) begin
        nxt[int'(wr_addr_in)] = wake(wr_data_in);
        nxt[int'(wr_addr_in)].busy = 1'b1;
      end else begin
        m_ov = 1;
      end
    end
    m_cell = nxt;
  endtask

  task automatic compare_all();
    logic [DEPTH-1:0] exp_busy;
    for (int i = 0; i < DEPTH; i++) exp_busy[i] = m_cell[i].busy;
    check("valid", 128'(issue_valid_out), 128'(m_valid));
    check("busy_vec", 128'(busy_vec_out), 128'(exp_busy));
    check("full", 128'(full_out), 128'(&exp_busy));
    check("overflow", 128'(overflow_out), 128'(m_ov));
    if (m_valid) begin
      check("idx", 128'(issue_idx_out), 128'(m_idx));
      check("data", 128'(issue_data_out), 128'(m_data));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    flush_in     = 1'b0;
    wr_en_in     = 1'b0;
    cdb_valid_in = 1'b0;
    cdb_tag_in   = '0;
    cdb_data_in  = '0;
  endtask

  task automatic do_write(input int addr, input res_st_cell_t c);
    wr_en_in   = 1'b1;
    wr_addr_in = res_st_addr_t'(addr);
    wr_data_in = c;
  endtask

  function automatic res_st_cell_t mk_cell(input int qj, input logic [31:0] vj, input int qk,
                                           input logic [31:0] vk, input int op);
    res_st_cell_t c;
    c.qj   = phy_tag_t'(qj);
    c.vj   = vj;
    c.qk   = phy_tag_t'(qk);
    c.vk   = vk;
    c.a    = 32'hA000_0000 + 32'(op);
    c.op   = RES_ST_OP_WIDTH'(op);
    c.busy = 1'b0;
    return c;
  endfunction

  function automatic int rand_tag();
    return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7));
  endfunction

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_valid", 128'(issue_valid_out), 128'(0));
    check("reset_busy", 128'(busy_vec_out), 128'(0));
    check("reset_full", 128'(full_out), 128'(0));
    check("reset_ovf", 128'(overflow_out), 128'(0));
    check("reset_data", 128'(issue_data_out), 128'(0));
    rst_n = 1'b1;

    // Ready write: valid rises after the second edge.
    issue_ready_in = 1'b1;
    do_write(0, mk_cell(0, 5, 0, 7, 3));
    tick();
    idle();
    check("t1_not_yet", 128'(issue_valid_out), 128'(0));
    tick();
    check("t1_valid", 128'(issue_valid_out), 128'(1));
    check("t1_idx", 128'(issue_idx_out), 128'(0));
    check("t1_vj", 128'(issue_data_out.vj), 128'(5));
    check("t1_vk", 128'(issue_data_out.vk), 128'(7));
    check("t1_op", 128'(issue_data_out.op), 128'(3));
    check("t1_busy0", 128'(busy_vec_out[0]), 128'(0));
    tick();

    // Wakeup, with a tag-0 broadcast that must be ignored first.
    do_write(2, mk_cell(12, 0, 0, 1, 1));
    tick();
    idle();
    cdb_valid_in = 1'b1; cdb_tag_in = '0; cdb_data_in = 32'h1234;
    tick();
    check("t2_tag0_busy", 128'(busy_vec_out[2]), 128'(1));
    check("t2_tag0_valid", 128'(issue_valid_out), 128'(0));
    cdb_tag_in = 6'd12; cdb_data_in = 32'hDEADBEEF;
    tick();
    idle();
    check("t2_wake_wait", 128'(issue_valid_out), 128'(0));
    tick();
    check("t2_valid", 128'(issue_valid_out), 128'(1));
    check("t2_idx", 128'(issue_idx_out), 128'(2));
    check("t2_vj", 128'(issue_data_out.vj), 128'(32'hDEADBEEF));
    tick();

    // Same-cycle bypass of the incoming write.
    do_write(1, mk_cell(0, 3, 9, 0, 2));
    cdb_valid_in = 1'b1; cdb_tag_in = 6'd9; cdb_data_in = 32'd42;
    tick();
    idle();
    tick();
    check("t3_valid", 128'(issue_valid_out), 128'(1));
    check("t3_idx", 128'(issue_idx_out), 128'(1));
    check("t3_vk", 128'(issue_data_out.vk), 128'(42));
    tick();

    // Backpressure with entries 3 and 5 ready.
    issue_ready_in = 1'b0;
    do_write(3, mk_cell(0, 33, 0, 34, 4));
    tick();
    do_write(5, mk_cell(0, 55, 0, 56, 6));
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_hold_idx", 128'(issue_idx_out), 128'(3));
      check("t4_busy5", 128'(busy_vec_out[5]), 128'(1));
    end
    issue_ready_in = 1'b1;
    tick();
    check("t4_next_idx", 128'(issue_idx_out), 128'(5));
    tick();
    check("t4_drained", 128'(issue_valid_out), 128'(0));

    // Full and overflow.
    for (int i = 0; i < DEPTH; i++) begin
      do_write(i, mk_cell(4, 0, 0, 0, i));
      tick();
    end
    check("t5_full", 128'(full_out), 128'(1));
    do_write(0, mk_cell(4, 99, 0, 99, 15));
    tick();
    idle();
    check("t5_ovf", 128'(overflow_out), 128'(1));
    tick();
    check("t5_ovf_pulse", 128'(overflow_out), 128'(0));
    cdb_valid_in = 1'b1; cdb_tag_in = 6'd4; cdb_data_in = 32'h77;
    tick();
    idle();
    tick();
    check("t5_first_idx", 128'(issue_idx_out), 128'(0));
    check("t5_first_op", 128'(issue_data_out.op), 128'(0));
    repeat (DEPTH + 1) tick();

    // Flush with six waiting entries and a held output.
    issue_ready_in = 1'b0;
    do_write(6, mk_cell(0, 1, 0, 2, 7));
    tick();
    for (int i = 0; i < 6; i++) begin
      do_write(i, mk_cell(4, 0, 0, 0, i));
      tick();
    end
    idle();
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    check("t6_flush_busy", 128'(busy_vec_out), 128'(0));
    check("t6_flush_valid", 128'(issue_valid_out), 128'(0));

    // Asynchronous reset in the middle of issuing.
    issue_ready_in = 1'b1;
    do_write(2, mk_cell(0, 8, 0, 9, 5));
    tick();
    do_write(4, mk_cell(3, 8, 0, 9, 5));
    tick();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 128'(issue_valid_out), 128'(0));
    check("t6_rst_busy", 128'(busy_vec_out), 128'(0));
    check("t6_rst_full", 128'(full_out), 128'(0));
    check("t6_rst_data", 128'(issue_data_out), 128'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      res_st_cell_t c;
      wr_en_in   = ($urandom_range(0, 99) < 55);
      wr_addr_in = res_st_addr_t'($urandom_range(0, DEPTH - 1));
      c = mk_cell(rand_tag(), $urandom, rand_tag(), $urandom, int'($urandom_range(0, 15)));
      c.a    = $urandom;
      c.busy = 1'($urandom_range(0, 1));
      wr_data_in     = c;
      cdb_valid_in   = ($urandom_range(0, 99) < 50);
      cdb_tag_in     = phy_tag_t'($urandom_range(0, 7));
      cdb_data_in    = $urandom;
      issue_ready_in = ($urandom_range(0, 99) < 70);
      flush_in       = ($urandom_range(0, 99) < 2);
      tick();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/res_st_buffer.md
# res_st_buffer

Reservation-station storage and issue block: the receiving end of the rename stage's write port. Holds up to RES_ST_DEPTH renamed micro-ops, wakes pending operands by snooping the common data bus (CDB), and issues the lowest-index ready entry into a registered valid/ready output toward the execution units. Sits between rename and the functional units.

## Interface
- RES_ST_DEPTH, 8: number of entries; power of two; the index width is that of res_st_addr_t.
- PHY_RF_ADDR_WIDTH, package value: physical tag width. Tag 0 means "no pending producer".
- RES_ST_OP_WIDTH, package value: op field width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- flush_in  in  1  synchronous clear of all entries and the output register.
- wr_en_in  in  1  write strobe from rename.
- wr_addr_in  in  res_st_addr_t  target entry.
- wr_data_in  in  res_st_cell_t  cell contents: qj, vj, qk, vk, a, op, busy.
- cdb_valid_in  in  1  broadcast valid.
- cdb_tag_in  in  PHY_RF_ADDR_WIDTH  producing physical register.
- cdb_data_in  in  32  produced value.
- issue_valid_out  out  1  output register holds an issued op.
- issue_ready_in  in  1  consumer accepts the op.
- issue_idx_out  out  res_st_addr_t  entry index the op came from.
- issue_data_out  out  res_st_cell_t  issued cell; qj and qk are always 0.
- busy_vec_out  out  RES_ST_DEPTH  per-entry busy bits, registered.
- full_out  out  1  all entries busy, registered.
- overflow_out  out  1  one-cycle pulse when a write hits an occupied entry.

## Operation
- **Entry ready condition:** busy && qj==0 && qk==0.
- **Write:**
  - If wr_en_in is high and entry wr_addr_in is free, or is being issued this cycle, store wr_data_in with busy forced to 1.
  - If the entry is occupied and not leaving this cycle, drop the write and pulse overflow_out.
- **Wakeup:** when cdb_valid_in is high and cdb_tag_in is nonzero:
  - Every busy entry with qj==cdb_tag_in loads vj=cdb_data_in and clears qj. The same applies to qk/vk.
  - The incoming write cell gets the same comparison (same-cycle bypass), so an operand produced in the rename cycle is not lost.
  - A broadcast with cdb_tag_in==0 is ignored.
- **Select:** fixed priority, lowest ready index wins. Readiness uses registered entry state only; a wakeup makes an entry eligible one cycle later.
- **Issue:**
  - Load condition: the output register is empty, or issue_ready_in is high, and a ready entry exists.
  - On load: the selected cell goes to issue_data_out, its index to issue_idx_out, issue_valid_out is set, and the entry's busy bit clears at the same edge.
  - If issue_valid_out && issue_ready_in and nothing is ready, issue_valid_out clears.
  - While issue_valid_out && !issue_ready_in, the outputs hold stable.
- **Flush:** clears all busy bits and issue_valid_out. It wins over a same-cycle write, wakeup and issue.

## Timing
- **Reset:** all outputs 0, all entries free. Asserting rst_n low mid-operation discards everything at once.
- **Latency:**
  - Write at edge N with both operands ready: issue_valid_out rises after edge N+1.
  - Operand woken at edge N: entry eligible in cycle N+1, issued at edge N+1.
- **Throughput:** one issue per cycle under continuous issue_ready_in.
- **busy_vec_out / full_out:** reflect the state after the previous edge.
  - A write and an issue to different entries in the same cycle both take effect.
  - A write and an issue to the same entry: the new op occupies the entry.

## Structure
- Shared package qu_common: res_st_addr_t, res_st_cell_t, RES_ST_DEPTH default, PHY_RF_ADDR_WIDTH, RES_ST_OP_WIDTH.
- Sub-module res_st_select: combinational lowest-index priority picker. Inputs are the ready vector; outputs are a found flag and an index.

## Test plan
- **Ready write:** write entry 0 with qj=0, qk=0, vj=5, vk=7, op=3, issue_ready_in=1 -> issue_valid_out high two cycles after the write; issue_data_out.vj=5, vk=7; issue_idx_out=0; busy_vec_out[0] returns to 0.
- **Wakeup:** write entry 2 with qj=12, qk=0, then CDB tag 12 data 0xDEADBEEF -> issued one cycle after the broadcast with vj=0xDEADBEEF. A CDB broadcast with tag 0 produces no change.
- **Same-cycle bypass:** write entry 1 with qk=9 while the CDB broadcasts tag 9 data 42 -> entry issues with vk=42 and does not wait.
- **Backpressure:** entries 3 and 5 ready, issue_ready_in=0 for 4 cycles -> idx 3 held stable with entry 5 still busy; after ready rises, idx 3 is accepted, then idx 5.
- **Full and overflow:** fill all 8 entries with qj=4 -> full_out=1; a ninth write to entry 0 -> overflow_out pulses for one cycle and the contents are unchanged.
- **Flush and reset:** flush_in with 6 entries busy and the output valid -> busy_vec_out=0 and issue_valid_out=0 next cycle. Asserting rst_n low mid-issue -> all outputs 0 immediately.
